// File: rtl/cond_accum_pkg.sv
// Shared types and helpers for the conditional accumulate-and-square engine.
//   state_e     : control FSM states (idle, multiply, hold result).
//   MaxDepth    : largest supported parity history length.
//   parity_fold : XOR-fold of the parity history plus the condition bit folded
//                 'depth' times (so it only survives for odd depths).
package cond_accum_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMult,
    StHold
  } state_e;

  localparam int unsigned MaxDepth = 256;

  // Unused upper history bits must be zero; they then drop out of the XOR.
  function automatic logic parity_fold(input logic [MaxDepth-1:0] hist,
                                       input logic                cond,
                                       input int unsigned         depth);
    return (^hist) ^ (cond & depth[0]);
  endfunction

endpackage

// File: rtl/cond_accum_mul.sv
// Iterative squarer, radix 2^RADIX, keeping the low WIDTH bits of operand^2.
// Ports:
//   clk     : clock, rising edge
//   rst_n   : synchronous active-low reset, clears all state
//   start   : latch 'operand' and begin a new square
//   operand : value to be squared
//   done    : high during the last of the WIDTH/RADIX working cycles; the
//             value on 'product' is final in that cycle
//   product : running truncated product (final while done is high)
module cond_accum_mul #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RADIX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] operand,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned N    = WIDTH / RADIX;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CntW-1:0]  cnt_q;
  logic             run_q;

  logic [WIDTH-1:0] digit;
  logic [WIDTH-1:0] partial;

  // Multiplicand is pre-shifted each cycle, so the partial product of the
  // current digit lands at the right weight; overflow past WIDTH is dropped.
  assign digit   = WIDTH'(mplier_q[RADIX-1:0]);
  assign partial = mcand_q * digit;
  assign product = acc_q + partial;
  assign done    = run_q && (cnt_q == CntW'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= operand;
      mplier_q <= operand;
      cnt_q    <= '0;
      run_q    <= 1'b1;
    end else if (run_q) begin
      acc_q    <= product;
      mcand_q  <= mcand_q << RADIX;
      mplier_q <= mplier_q >> RADIX;
      cnt_q    <= cnt_q + CntW'(1);
      if (done) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cond_accum_sq.sv
// Conditional accumulate-and-square engine with parity-feedback history.
// Each accepted operand updates a parity bit from the history and in_cond; the
// parity picks add or subtract of the operand into the accumulator, and the
// result is squared (mod 2^WIDTH) over WIDTH/RADIX cycles.
// Ports:
//   clk, rst_n            : clock; synchronous active-low reset
//   in_valid/in_ready     : operand handshake (ready only while idle)
//   in_cond, in_comp      : condition bit and operand
//   out_valid/out_ready   : result handshake; result held until accepted
//   out, out_parity       : squared accumulator and the parity that produced it
//   busy                  : multiplying or holding a result
module cond_accum_sq
  import cond_accum_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 10,
  parameter int unsigned RADIX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_cond,
  input  logic [WIDTH-1:0] in_comp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_parity,
  output logic             busy
);

  if ((RADIX < 1) || (RADIX > WIDTH) || ((WIDTH % RADIX) != 0) ||
      (DEPTH < 1) || (DEPTH > MaxDepth)) begin : gen_param_check
    $error("cond_accum_sq: illegal WIDTH/DEPTH/RADIX combination");
  end

  state_e state_q, state_d;

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] out_q;
  logic [DEPTH-1:0] hist_q;
  logic             o_q;
  logic             par_q;
  logic             out_valid_q;

  logic             accept;
  logic             o_new;
  logic [WIDTH-1:0] sum;
  logic [DEPTH-1:0] hist_shift;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign accept = (state_q == StIdle) && in_valid;
  assign o_new  = o_q ^ parity_fold(MaxDepth'(hist_q), in_cond, DEPTH);
  assign sum    = o_new ? (value_q + in_comp) : (value_q - in_comp);

  if (DEPTH == 1) begin : gen_hist_one
    assign hist_shift = o_new;
  end else begin : gen_hist_many
    assign hist_shift = {hist_q[DEPTH-2:0], o_new};
  end

  cond_accum_mul #(
    .WIDTH (WIDTH),
    .RADIX (RADIX)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept),
    .operand (sum),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid)  state_d = StMult;
      StMult:  if (mul_done)  state_d = StHold;
      StHold:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      value_q     <= '0;
      out_q       <= '0;
      hist_q      <= '0;
      o_q         <= 1'b0;
      par_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        o_q    <= o_new;
        hist_q <= hist_shift;
      end
      if (mul_done) begin
        value_q     <= mul_product;
        out_q       <= mul_product;
        par_q       <= o_q;
        out_valid_q <= 1'b1;
      end else if ((state_q == StHold) && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign out_valid  = out_valid_q;
  assign out        = out_q;
  assign out_parity = par_q;

endmodule

// File: tb/tb_cond_accum_sq.sv
module tb_cond_accum_sq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_cond;
  logic [31:0] in_comp;
  logic        out_ready;

  logic        iv [4];
  logic        ir [4];
  logic        ov [4];
  logic        op [4];
  logic        bz [4];
  logic [31:0] ot [4];

  int errors = 0;
  int checks = 0;

  // 0: DEPTH=10 RADIX=8; 1..3: DEPTH=9 with RADIX 8, 1, 32
  cond_accum_sq #(.WIDTH(32), .DEPTH(10), .RADIX(8)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_cond(in_cond),
    .in_comp(in_comp), .out_valid(ov[0]), .out_ready(out_ready), .out(ot[0]),
    .out_parity(op[0]), .busy(bz[0])
  );
  cond_accum_sq #(.WIDTH(32), .DEPTH(9), .RADIX(8)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_cond(in_cond),
    .in_comp(in_comp), .out_valid(ov[1]), .out_ready(out_ready), .out(ot[1]),
    .out_parity(op[1]), .busy(bz[1])
  );
  cond_accum_sq #(.WIDTH(32), .DEPTH(9), .RADIX(1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_cond(in_cond),
    .in_comp(in_comp), .out_valid(ov[2]), .out_ready(out_ready), .out(ot[2]),
    .out_parity(op[2]), .busy(bz[2])
  );
  cond_accum_sq #(.WIDTH(32), .DEPTH(9), .RADIX(32)) u_d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .in_cond(in_cond),
    .in_comp(in_comp), .out_valid(ov[3]), .out_ready(out_ready), .out(ot[3]),
    .out_parity(op[3]), .busy(bz[3])
  );

  // DEPTH=9 directed sequence, expected values worked out by hand
  localparam logic        CondTab [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [31:0] CompTab [6] = '{32'd3, 32'd2, 32'd50, 32'hFFFFD9B7, 32'd1, 32'd5};
  localparam logic [31:0] OutTab  [6] = '{32'd9, 32'd49, 32'd9801, 32'd0, 32'd1, 32'd16};
  localparam logic        ParTab  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam int          LatTab  [4] = '{4, 4, 32, 1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge with instance k idle.
  task automatic txn(input int k, input logic cond, input logic [31:0] comp,
                     input logic [31:0] exp, input logic exp_par, input int exp_lat,
                     input string tag);
    int lat;
    chk({tag, " ready_before"}, ir[k], 1);
    in_cond = cond;
    in_comp = comp;
    iv[k]   = 1'b1;
    @(posedge clk); #1;
    iv[k] = 1'b0;
    lat   = 0;
    while (!ov[k] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " out"}, ot[k], exp);
    chk({tag, " parity"}, op[k], exp_par);
    chk({tag, " ready_hold"}, ir[k], 0);
    chk({tag, " busy_hold"}, bz[k], 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " valid_after"}, ov[k], 0);
    chk({tag, " ready_after"}, ir[k], 1);
    chk({tag, " out_kept"}, ot[k], exp);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_cond   = 1'b0;
    in_comp   = '0;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) iv[k] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_valid%0d", k), ov[k], 0);
      chk($sformatf("rst_out%0d", k), ot[k], 0);
      chk($sformatf("rst_par%0d", k), op[k], 0);
      chk($sformatf("rst_ready%0d", k), ir[k], 1);
      chk($sformatf("rst_busy%0d", k), bz[k], 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // DEPTH even: parity stays 0, always subtract; in_cond cancels
    txn(0, 1'b0, 32'd3, 32'd9, 1'b0, 4, "a1");
    txn(0, 1'b0, 32'd2, 32'd49, 1'b0, 4, "a2");
    txn(0, 1'b1, 32'd1, 32'd2304, 1'b0, 4, "a3_cond_cancel");

    // Stall in HOLD with in_valid pulses that must be ignored: 2304-4 = 2300
    in_cond = 1'b0;
    in_comp = 32'd4;
    iv[0]   = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("stall valid", ov[0], 1);
    chk("stall out", ot[0], 32'h0050B810);
    for (int i = 0; i < 5; i++) begin
      iv[0]   = 1'b1;
      in_comp = 32'h55;
      @(posedge clk); #1;
      chk($sformatf("stall%0d out", i), ot[0], 32'h0050B810);
      chk($sformatf("stall%0d valid", i), ov[0], 1);
      chk($sformatf("stall%0d ready", i), ir[0], 0);
    end
    iv[0]     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("stall release valid", ov[0], 0);
    chk("stall release ready", ir[0], 1);
    chk("stall release out", ot[0], 32'h0050B810);

    // Reset during the second MULT cycle discards the in-flight result
    in_comp = 32'd1;
    iv[0]   = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    chk("midrst busy", bz[0], 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst valid", ov[0], 0);
    chk("midrst ready", ir[0], 1);
    chk("midrst busy_after", bz[0], 0);
    chk("midrst out", ot[0], 0);
    @(posedge clk); #1;
    txn(0, 1'b0, 32'd3, 32'd9, 1'b0, 4, "a_after_rst");

    // DEPTH odd, three radices: identical results, latency 4 / 32 / 1
    for (int k = 1; k < 4; k++) begin
      for (int s = 0; s < 6; s++) begin
        txn(k, CondTab[s], CompTab[s], OutTab[s], ParTab[s], LatTab[k],
            $sformatf("d9_r%0d_s%0d", k, s));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
